// File: rtl/alu_controle_pipe.sv
// alu_controle_pipe: ALU control decode for the pipelined RISC-V datapath,
// followed by STAGES valid/ready register slots. Illegal encodings are coded
// as 1111 and flagged, and they travel down the pipe like any other entry.
// Optional feature macro: CONTADOR_ILEGAL_EN adds the saturating cont_ilegal
// counter of illegal entries handed downstream.
module alu_controle_pipe #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valido,
    output logic            in_pronto,
    input  logic [1:0]      ALUop,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    output logic            out_valido,
    input  logic            out_pronto,
    output logic [OP_W-1:0] operacao_selecionada,
    output logic            op_ilegal
`ifdef CONTADOR_ILEGAL_EN
    ,
    output logic [CNT_W-1:0] cont_ilegal
`endif
);

    typedef enum logic [3:0] {
        OP_AND     = 4'b0000,
        OP_OR      = 4'b0001,
        OP_ADD     = 4'b0010,
        OP_SLL     = 4'b0011,
        OP_XOR     = 4'b0100,
        OP_SRL     = 4'b0101,
        OP_SUB     = 4'b0110,
        OP_SRA     = 4'b0111,
        OP_SLT     = 4'b1000,
        OP_SLTU    = 4'b1001,
        OP_ILLEGAL = 4'b1111
    } alu_op_e;

    if (OP_W < 4 || STAGES < 1 || STAGES > 4 || CNT_W < 1) begin : g_param_check
        $error("alu_controle_pipe: OP_W must be >= 4, STAGES 1..4, CNT_W >= 1");
    end

    alu_op_e             dec_op;
    logic                dec_ilegal;
    logic [OP_W-1:0]     dec_op_ext;

    logic [STAGES-1:0]   slot_valid;
    logic [STAGES-1:0]   slot_ilegal;
    logic [OP_W-1:0]     slot_op [STAGES];
    logic [STAGES-1:0]   pronto;

    // Decode ALUop/funct3/funct7_5 into an operation code at the pipe input.
    // For I-type, bit 30 is immediate data except for SRAI; only SLLI with it
    // set is an illegal encoding.
    always_comb begin
        dec_op     = OP_ADD;
        dec_ilegal = 1'b0;
        unique case (ALUop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            default: begin
                unique case (funct3)
                    3'b000: dec_op = (funct7_5 && !ALUop[0]) ? OP_SUB : OP_ADD;
                    3'b001: dec_op = OP_SLL;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_XOR;
                    3'b101: dec_op = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110: dec_op = OP_OR;
                    default: dec_op = OP_AND;
                endcase
                if (funct7_5 && funct3 != 3'b000 && funct3 != 3'b101 &&
                    (!ALUop[0] || funct3 == 3'b001)) begin
                    dec_ilegal = 1'b1;
                end
            end
        endcase
        if (dec_ilegal) begin
            dec_op = OP_ILLEGAL;
        end
    end

    assign dec_op_ext = OP_W'(dec_op);

    // Ready chain from the output slot back to the input: a slot may load when
    // it is empty or the slot after it can load.
    always_comb begin
        pronto = '0;
        pronto[STAGES-1] = !slot_valid[STAGES-1] | out_pronto;
        for (int unsigned k = 1; k < STAGES; k++) begin
            pronto[STAGES-1-k] = !slot_valid[STAGES-1-k] | pronto[STAGES-k];
        end
    end

    // Slot registers: load from upstream when ready, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid  <= '0;
            slot_ilegal <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                slot_op[i] <= '0;
            end
        end else begin
            if (pronto[0]) begin
                slot_valid[0]  <= in_valido;
                slot_op[0]     <= dec_op_ext;
                slot_ilegal[0] <= dec_ilegal;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (pronto[i]) begin
                    slot_valid[i]  <= slot_valid[i-1];
                    slot_op[i]     <= slot_op[i-1];
                    slot_ilegal[i] <= slot_ilegal[i-1];
                end
            end
        end
    end

    assign in_pronto            = pronto[0] & !reset;
    assign out_valido           = slot_valid[STAGES-1];
    assign operacao_selecionada = slot_op[STAGES-1];
    assign op_ilegal            = slot_ilegal[STAGES-1];

`ifdef CONTADOR_ILEGAL_EN
    // Count illegal entries taken by the downstream stage, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            cont_ilegal <= '0;
        end else if (out_valido && out_pronto && op_ilegal && cont_ilegal != '1) begin
            cont_ilegal <= cont_ilegal + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_controle_pipe.sv
// Self-checking bench for alu_controle_pipe: three instances (STAGES 1, 2, 3;
// the STAGES=3 one with a 6-bit op port) share the same stimulus and are each
// compared every cycle against a slot-occupancy reference model.
module tb_alu_controle_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b1;
    logic       in_valido = 1'b0;
    logic       out_pronto = 1'b0;
    logic [1:0] ALUop     = 2'b00;
    logic [2:0] funct3    = 3'b000;
    logic       funct7_5  = 1'b0;

    logic       ip0, ip1, ip2, ov0, ov1, ov2, il0, il1, il2;
    logic [3:0] op0, op1;
    logic [5:0] op2;
`ifdef CONTADOR_ILEGAL_EN
    logic [1:0] cnt0, cnt1, cnt2;
    int         m_cnt [3];
`endif

    alu_controle_pipe #(.OP_W(4), .STAGES(1), .CNT_W(2)) u_s1 (
        .clk(clk), .reset(reset), .in_valido(in_valido), .in_pronto(ip0),
        .ALUop(ALUop), .funct3(funct3), .funct7_5(funct7_5),
        .out_valido(ov0), .out_pronto(out_pronto),
        .operacao_selecionada(op0), .op_ilegal(il0)
`ifdef CONTADOR_ILEGAL_EN
        , .cont_ilegal(cnt0)
`endif
    );

    alu_controle_pipe #(.OP_W(4), .STAGES(2), .CNT_W(2)) u_s2 (
        .clk(clk), .reset(reset), .in_valido(in_valido), .in_pronto(ip1),
        .ALUop(ALUop), .funct3(funct3), .funct7_5(funct7_5),
        .out_valido(ov1), .out_pronto(out_pronto),
        .operacao_selecionada(op1), .op_ilegal(il1)
`ifdef CONTADOR_ILEGAL_EN
        , .cont_ilegal(cnt1)
`endif
    );

    alu_controle_pipe #(.OP_W(6), .STAGES(3), .CNT_W(2)) u_s3 (
        .clk(clk), .reset(reset), .in_valido(in_valido), .in_pronto(ip2),
        .ALUop(ALUop), .funct3(funct3), .funct7_5(funct7_5),
        .out_valido(ov2), .out_pronto(out_pronto),
        .operacao_selecionada(op2), .op_ilegal(il2)
`ifdef CONTADOR_ILEGAL_EN
        , .cont_ilegal(cnt2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, slot j holds {valid, ilegal, op}
    bit         m_v   [3][4];
    bit         m_il  [3][4];
    logic [3:0] m_op  [3][4];
    bit         m_rst [3];
    bit         armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode table: {ilegal, code}
    function automatic logic [4:0] ref_decode(logic [1:0] ao, logic [2:0] f3, logic f7);
        logic [3:0] base [8];
        base = '{4'h2, 4'h3, 4'h8, 4'h9, 4'h4, 4'h5, 4'h1, 4'h0};
        if (ao == 2'b00) return 5'h02;
        if (ao == 2'b01) return 5'h06;
        if (!f7) return {1'b0, base[f3]};
        if (f3 == 3'd5) return 5'h07;
        if (f3 == 3'd0) return (ao == 2'b10) ? 5'h06 : 5'h02;
        if (ao == 2'b11 && f3 != 3'd1) return {1'b0, base[f3]};
        return 5'h1F;
    endfunction

    task automatic cycle(input bit rst, input bit iv, input logic [1:0] ao,
                         input logic [2:0] f3, input bit f7, input bit opr);
        @(negedge clk);
        reset = rst; in_valido = iv; ALUop = ao; funct3 = f3; funct7_5 = f7; out_pronto = opr;
        #1;
        for (int d = 0; d < 3; d++) begin
            int          s;
            int          b;
            logic [4:0]  dec;
            bit          a_v, a_il, a_ip;
            logic [31:0] a_op;
            s   = d + 1;
            dec = ref_decode(ao, f3, f7);
            // b = highest slot that loads this edge (-1: whole pipe stalled)
            b = -1;
            if (!m_v[d][s-1] || opr) b = s - 1;
            else for (int j = 0; j < s - 1; j++) if (!m_v[d][j]) b = j;
            case (d)
                0: begin a_v = ov0; a_op = 32'(op0); a_il = il0; a_ip = ip0; end
                1: begin a_v = ov1; a_op = 32'(op1); a_il = il1; a_ip = ip1; end
                default: begin a_v = ov2; a_op = 32'(op2); a_il = il2; a_ip = ip2; end
            endcase
            if (armed) begin
                check($sformatf("s%0d out_valido", s), 32'(a_v), 32'(m_v[d][s-1]));
                check($sformatf("s%0d in_pronto", s), 32'(a_ip), 32'(!rst && b >= 0));
                if (m_v[d][s-1]) begin
                    check($sformatf("s%0d op", s), a_op, 32'(m_op[d][s-1]));
                    check($sformatf("s%0d op_ilegal", s), 32'(a_il), 32'(m_il[d][s-1]));
                end
                if (m_rst[d]) begin
                    check($sformatf("s%0d op after reset", s), a_op, 32'd0);
                    check($sformatf("s%0d ilegal after reset", s), 32'(a_il), 32'd0);
                end
`ifdef CONTADOR_ILEGAL_EN
                case (d)
                    0: check("s1 cont_ilegal", 32'(cnt0), 32'(m_cnt[0]));
                    1: check("s2 cont_ilegal", 32'(cnt1), 32'(m_cnt[1]));
                    default: check("s3 cont_ilegal", 32'(cnt2), 32'(m_cnt[2]));
                endcase
                if (rst) m_cnt[d] = 0;
                else if (m_v[d][s-1] && opr && m_il[d][s-1] && m_cnt[d] < 3) m_cnt[d]++;
`endif
            end
            if (rst) begin
                for (int j = 0; j < 4; j++) begin
                    m_v[d][j] = 1'b0; m_il[d][j] = 1'b0; m_op[d][j] = 4'h0;
                end
                m_rst[d] = 1'b1;
            end else begin
                m_rst[d] = 1'b0;
                if (b >= 0) begin
                    for (int j = b; j >= 1; j--) begin
                        m_v[d][j] = m_v[d][j-1]; m_il[d][j] = m_il[d][j-1]; m_op[d][j] = m_op[d][j-1];
                    end
                    m_v[d][0] = iv; m_il[d][0] = dec[4]; m_op[d][0] = dec[3:0];
                end
            end
        end
        if (rst) armed = 1'b1;
    endtask

    initial begin
        // reset, then T1: R-type SUB then I-type ADD with bit 30 set
        cycle(1, 0, 2'b00, 3'd0, 0, 0);
        cycle(1, 0, 2'b00, 3'd0, 0, 0);
        cycle(0, 1, 2'b10, 3'd0, 1, 1);
        cycle(0, 1, 2'b11, 3'd0, 1, 1);
        cycle(0, 0, 2'b00, 3'd0, 0, 1);
        check("t1 sub code", 32'(op1), 32'h6);
        cycle(0, 0, 2'b00, 3'd0, 0, 1);
        check("t1 addi code", 32'(op1), 32'h2);

        // T2: 8 back-to-back ops, then drain
        for (int k = 0; k < 8; k++) cycle(0, 1, 2'($urandom), 3'($urandom), 1'($urandom), 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 2'b00, 3'd0, 0, 1);

        // T3: stall 5 cycles while feeding, then release
        for (int k = 0; k < 5; k++) cycle(0, 1, 2'b10, 3'(k), 0, 0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 2'b00, 3'd0, 0, 1);

        // T4: five illegal ops in a row
        for (int k = 0; k < 5; k++) cycle(0, 1, 2'b10, 3'b110, 1, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 2'b00, 3'd0, 0, 1);

        // T5: fill and stall, reset mid-stream, resume
        for (int k = 0; k < 6; k++) cycle(0, 1, 2'b10, 3'b100, 0, 0);
        cycle(1, 1, 2'b10, 3'b100, 0, 0);
        cycle(0, 1, 2'b01, 3'd0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 2'b00, 3'd0, 0, 1);

        // T6: sweep all 64 encodings back-to-back
        for (int k = 0; k < 64; k++) cycle(0, 1, 2'(k >> 4), 3'(k >> 1), 1'(k), 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 2'b00, 3'd0, 0, 1);

        // random traffic with random back-pressure and occasional reset
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, 2'($urandom),
                  3'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
